// File: rtl/if_id_ctrl.sv
// Front-end controller for PC / IF_ID: stall, hold, flush and bubble generation with deferred
// branch redirect across an outstanding I-fetch. Optional perf counters under `PERF_CNT_EN`.
module if_id_ctrl #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              icache_stall_i,
  input  logic              dcache_stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              ex_memread_i,
  input  logic [REG_W-1:0]  ex_rt_i,
  input  logic [REG_W-1:0]  id_rs_i,
  input  logic [REG_W-1:0]  id_rt_i,
  output logic              pc_enable_o,
  output logic              pc_sel_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              hz_o,
  output logic              flush_o,
  output logic              bubble_o,
  output logic              stall_all_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_o,
  output logic [CNT_W-1:0]  perf_flush_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IMISS    = 2'd1,
    IMISS_RD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic                lu;

  assign lu = ex_memread_i && (ex_rt_i != '0) &&
              ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    pc_enable_o = 1'b1;
    pc_sel_o    = 1'b0;
    hz_o        = 1'b0;
    flush_o     = 1'b0;
    bubble_o    = 1'b0;
    stall_all_o = 1'b0;

    if (dcache_stall_i) begin
      stall_all_o = 1'b1;
      hz_o        = 1'b1;
      pc_enable_o = 1'b0;
    end else begin
      unique case (state_q)
        RUN, IMISS: begin
          if (state_q == IMISS && icache_stall_i) begin
            // Still waiting on the original fetch; a branch now must be replayed later.
            pc_enable_o = 1'b0;
            if (lu) begin
              hz_o     = 1'b1;
              bubble_o = 1'b1;
            end else begin
              flush_o = 1'b1;
              if (branch_taken_i) begin
                target_d = target_i;
                state_d  = IMISS_RD;
              end
            end
          end else begin
            state_d = RUN;
            if (lu) begin
              pc_enable_o = 1'b0;
              hz_o        = 1'b1;
              bubble_o    = 1'b1;
            end else if (icache_stall_i && branch_taken_i) begin
              target_d    = target_i;
              pc_enable_o = 1'b0;
              flush_o     = 1'b1;
              state_d     = IMISS_RD;
            end else if (icache_stall_i) begin
              pc_enable_o = 1'b0;
              flush_o     = 1'b1;
              state_d     = IMISS;
            end else if (branch_taken_i) begin
              flush_o = 1'b1;
            end
          end
        end
        IMISS_RD: begin
          if (icache_stall_i) begin
            pc_enable_o = 1'b0;
            if (lu) begin
              hz_o     = 1'b1;
              bubble_o = 1'b1;
            end else begin
              flush_o = 1'b1;
            end
          end else begin
            // Word just delivered belongs to the not-taken path: drop it and redirect.
            flush_o  = 1'b1;
            pc_sel_o = 1'b1;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_target_o = target_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_enable_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_o && (flush_cnt_q != '1))      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_o = stall_cnt_q;
  assign perf_flush_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed self-checking bench for if_id_ctrl; outputs are compared as the packed vector
// {pc_enable, pc_sel, hz, flush, bubble, stall_all}.
module tb_if_id_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        icache_stall_i, dcache_stall_i, branch_taken_i;
  logic [31:0] target_i;
  logic        ex_memread_i;
  logic [4:0]  ex_rt_i, id_rs_i, id_rt_i;
  logic        pc_enable_o, pc_sel_o, hz_o, flush_o, bubble_o, stall_all_o;
  logic [31:0] pc_target_o;
  logic [5:0]  outs;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

`ifdef PERF_CNT_EN
  logic [31:0] perf_stall_o, perf_flush_o;
  logic [1:0]  sat_stall_o, sat_flush_o;
  logic        s_pc_enable_o, s_pc_sel_o, s_hz_o, s_flush_o, s_bubble_o, s_stall_all_o;
  logic [31:0] s_pc_target_o;

  if_id_ctrl #(.ADDR_W(32), .REG_W(5), .CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .icache_stall_i(icache_stall_i),
    .dcache_stall_i(dcache_stall_i), .branch_taken_i(branch_taken_i), .target_i(target_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .pc_enable_o(s_pc_enable_o), .pc_sel_o(s_pc_sel_o), .pc_target_o(s_pc_target_o),
    .hz_o(s_hz_o), .flush_o(s_flush_o), .bubble_o(s_bubble_o), .stall_all_o(s_stall_all_o),
    .perf_stall_o(sat_stall_o), .perf_flush_o(sat_flush_o)
  );
`endif

  if_id_ctrl #(.ADDR_W(32), .REG_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .icache_stall_i(icache_stall_i),
    .dcache_stall_i(dcache_stall_i), .branch_taken_i(branch_taken_i), .target_i(target_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .pc_enable_o(pc_enable_o), .pc_sel_o(pc_sel_o), .pc_target_o(pc_target_o),
    .hz_o(hz_o), .flush_o(flush_o), .bubble_o(bubble_o), .stall_all_o(stall_all_o)
`ifdef PERF_CNT_EN
    ,
    .perf_stall_o(perf_stall_o), .perf_flush_o(perf_flush_o)
`endif
  );

  assign outs = {pc_enable_o, pc_sel_o, hz_o, flush_o, bubble_o, stall_all_o};

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    icache_stall_i = 1'b0; dcache_stall_i = 1'b0; branch_taken_i = 1'b0;
    target_i = 32'h0; ex_memread_i = 1'b0; ex_rt_i = 5'd0; id_rs_i = 5'd0; id_rt_i = 5'd0;
  endtask

  task automatic set_lu(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2);
    ex_memread_i = 1'b1; ex_rt_i = rt; id_rs_i = rs; id_rt_i = rt2;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b0;
    #3;
    tests_run++;
    if (outs !== 6'b100000 || pc_target_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got outs=%b target=%h, want outs=100000 target=0", outs, pc_target_o);
    end else $display("[TB] reset_outputs outs=%b target=%h", outs, pc_target_o);
    next_cycle(); next_cycle();
    rst_i = 1'b1;
  endtask

  task automatic test_perf();
`ifdef PERF_CNT_EN
    idle();
    set_lu(5'd5, 5'd5, 5'd0);
    repeat (4) next_cycle();
    idle();
    branch_taken_i = 1'b1; target_i = 32'h40;
    repeat (2) next_cycle();
    idle();
    #2;
    tests_run++;
    if (perf_stall_o !== 32'd4 || perf_flush_o !== 32'd2) begin
      tests_failed++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d, want stall=4 flush=2", perf_stall_o, perf_flush_o);
    end else $display("[TB] perf_counts stall=%0d flush=%0d", perf_stall_o, perf_flush_o);
    tests_run++;
    if (sat_stall_o !== 2'd3 || sat_flush_o !== 2'd2) begin
      tests_failed++;
      $display("FAIL perf_saturate: got stall=%0d flush=%0d, want stall=3 flush=2", sat_stall_o, sat_flush_o);
    end else $display("[TB] perf_saturate stall=%0d flush=%0d", sat_stall_o, sat_flush_o);
    next_cycle();
`endif
  endtask

  task automatic test_load_use();
    idle();
    set_lu(5'd5, 5'd5, 5'd0);
    #2;
    tests_run++;
    if (outs !== 6'b001010) begin
      tests_failed++;
      $display("FAIL lu_rs: got %b want 001010", outs);
    end else $display("[TB] lu_rs outs=%b", outs);
    next_cycle();
    set_lu(5'd7, 5'd1, 5'd7);
    #2;
    tests_run++;
    if (outs !== 6'b001010) begin
      tests_failed++;
      $display("FAIL lu_rt: got %b want 001010", outs);
    end else $display("[TB] lu_rt outs=%b", outs);
    next_cycle();
    set_lu(5'd0, 5'd0, 5'd0);
    #2;
    tests_run++;
    if (outs !== 6'b100000) begin
      tests_failed++;
      $display("FAIL lu_r0: got %b want 100000", outs);
    end else $display("[TB] lu_r0 outs=%b", outs);
    next_cycle();
    set_lu(5'd5, 5'd5, 5'd0);
    ex_memread_i = 1'b0;
    #2;
    tests_run++;
    if (outs !== 6'b100000) begin
      tests_failed++;
      $display("FAIL lu_noload: got %b want 100000", outs);
    end else $display("[TB] lu_noload outs=%b", outs);
    next_cycle();
    // Load-use beats a branch resolving in the same cycle.
    set_lu(5'd3, 5'd3, 5'd0);
    branch_taken_i = 1'b1; target_i = 32'h1234;
    #2;
    tests_run++;
    if (outs !== 6'b001010) begin
      tests_failed++;
      $display("FAIL lu_over_branch: got %b want 001010", outs);
    end else $display("[TB] lu_over_branch outs=%b", outs);
    next_cycle();
    idle();
  endtask

  task automatic test_branch();
    idle();
    branch_taken_i = 1'b1; target_i = 32'h40;
    #2;
    tests_run++;
    if (outs !== 6'b100100) begin
      tests_failed++;
      $display("FAIL branch_run: got %b want 100100", outs);
    end else $display("[TB] branch_run outs=%b", outs);
    next_cycle();
    idle();
    #2;
    tests_run++;
    if (outs !== 6'b100000 || pc_target_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL branch_after: got outs=%b target=%h want 100000 target=0", outs, pc_target_o);
    end else $display("[TB] branch_after outs=%b target=%h", outs, pc_target_o);
    next_cycle();
  endtask

  task automatic test_branch_in_miss();
    logic [5:0] exp_v [5];
    exp_v[0] = 6'b000100; exp_v[1] = 6'b000100; exp_v[2] = 6'b000100;
    exp_v[3] = 6'b110100; exp_v[4] = 6'b100000;
    for (int c = 0; c < 5; c++) begin
      idle();
      icache_stall_i = (c < 3);
      if (c == 1) begin branch_taken_i = 1'b1; target_i = 32'h80; end
      #2;
      tests_run++;
      if (outs !== exp_v[c] || (c >= 2 && pc_target_o !== 32'h80)) begin
        tests_failed++;
        $display("FAIL br_miss_c%0d: got outs=%b target=%h want outs=%b target=80", c, outs, pc_target_o, exp_v[c]);
      end else $display("[TB] br_miss_c%0d outs=%b target=%h", c, outs, pc_target_o);
      next_cycle();
    end
  endtask

  task automatic test_imiss_lu();
    idle();
    icache_stall_i = 1'b1;
    next_cycle();
    set_lu(5'd9, 5'd9, 5'd0);
    branch_taken_i = 1'b0;
    #2;
    tests_run++;
    if (outs !== 6'b001010) begin
      tests_failed++;
      $display("FAIL imiss_lu: got %b want 001010", outs);
    end else $display("[TB] imiss_lu outs=%b", outs);
    next_cycle();
    idle();
    branch_taken_i = 1'b1; target_i = 32'hA0;
    #2;
    tests_run++;
    if (outs !== 6'b100100) begin
      tests_failed++;
      $display("FAIL imiss_done_branch: got %b want 100100", outs);
    end else $display("[TB] imiss_done_branch outs=%b", outs);
    next_cycle();
    idle();
    #2;
    tests_run++;
    if (outs !== 6'b100000 || pc_target_o !== 32'h80) begin
      tests_failed++;
      $display("FAIL imiss_back_run: got outs=%b target=%h want 100000 target=80", outs, pc_target_o);
    end else $display("[TB] imiss_back_run outs=%b target=%h", outs, pc_target_o);
    next_cycle();
  endtask

  task automatic test_dstall_over_imiss_rd();
    idle();
    icache_stall_i = 1'b1; branch_taken_i = 1'b1; target_i = 32'h90;
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      idle();
      icache_stall_i = 1'b1; dcache_stall_i = 1'b1;
      branch_taken_i = 1'b1; target_i = 32'h11;
      #2;
      tests_run++;
      if (outs !== 6'b001001 || pc_target_o !== 32'h90) begin
        tests_failed++;
        $display("FAIL dstall_c%0d: got outs=%b target=%h want 001001 target=90", c, outs, pc_target_o);
      end else $display("[TB] dstall_c%0d outs=%b target=%h", c, outs, pc_target_o);
      next_cycle();
    end
    idle();
    icache_stall_i = 1'b1;
    set_lu(5'd4, 5'd0, 5'd4);
    #2;
    tests_run++;
    if (outs !== 6'b001010) begin
      tests_failed++;
      $display("FAIL imiss_rd_lu: got %b want 001010", outs);
    end else $display("[TB] imiss_rd_lu outs=%b", outs);
    next_cycle();
    idle();
    #2;
    tests_run++;
    if (outs !== 6'b110100 || pc_target_o !== 32'h90) begin
      tests_failed++;
      $display("FAIL dstall_resume: got outs=%b target=%h want 110100 target=90", outs, pc_target_o);
    end else $display("[TB] dstall_resume outs=%b target=%h", outs, pc_target_o);
    next_cycle();
  endtask

  task automatic test_reset_mid_miss();
    idle();
    icache_stall_i = 1'b1; branch_taken_i = 1'b1; target_i = 32'h55;
    next_cycle();
    idle();
    #2;
    tests_run++;
    if (outs !== 6'b110100 || pc_target_o !== 32'h55) begin
      tests_failed++;
      $display("FAIL pre_reset_rd: got outs=%b target=%h want 110100 target=55", outs, pc_target_o);
    end else $display("[TB] pre_reset_rd outs=%b target=%h", outs, pc_target_o);
    rst_i = 1'b0;
    #1;
    tests_run++;
    if (outs !== 6'b100000 || pc_target_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_miss: got outs=%b target=%h want 100000 target=0", outs, pc_target_o);
    end else $display("[TB] reset_mid_miss outs=%b target=%h", outs, pc_target_o);
    next_cycle();
    rst_i = 1'b1;
    next_cycle();
  endtask

  initial begin
    test_reset();
    next_cycle();
    test_perf();
    test_load_use();
    test_branch();
    test_branch_in_miss();
    test_imiss_lu();
    test_dstall_over_imiss_rd();
    test_reset_mid_miss();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
